fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: a single-outstanding memory request, a one-entry skid buffer and redirect/flush handling.
// Optional macro FETCH_TIMEOUT_EN adds a 255-cycle fetch watchdog that injects a NOP and raises a sticky fetch_err.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_rst,
  input  logic        if_en,
  output logic        if_valid,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        fetch_err
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, FETCH, FULL, DROP} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt, r_addr;
  logic [31:0] r_inst_out, r_pc_out, r_skid_inst, r_skid_pc;
  logic        r_if_valid;
  logic        w_busy, w_tmo, w_ack;
  logic [31:0] w_data, w_redirect_pc;
  logic        w_load_out, w_load_skid, w_from_skid, w_valid_clr;

  assign w_busy        = (r_state == FETCH) || (r_state == DROP);
  assign w_ack         = imem_ack || w_tmo;
  assign w_data        = imem_ack ? imem_data : 32'h0000_0000;
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load_out  = 1'b0;
    w_load_skid = 1'b0;
    w_from_skid = 1'b0;
    w_valid_clr = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = FETCH;
      FETCH: begin
        if (redirect || if_rst) begin
          if (redirect) w_pc_nxt = w_redirect_pc;
          w_valid_clr = 1'b1;
          // An ack in the same cycle retires the old request, so no drop is needed.
          w_state_nxt = w_ack ? FETCH : DROP;
        end else if (w_ack) begin
          w_pc_nxt = r_pc + 32'd4;
          if (if_en || !r_if_valid) begin
            w_load_out = 1'b1;
          end else begin
            w_load_skid = 1'b1;
            w_state_nxt = FULL;
          end
        end else if (if_en) begin
          w_valid_clr = 1'b1;
        end
      end
      FULL: begin
        if (redirect || if_rst) begin
          if (redirect) w_pc_nxt = w_redirect_pc;
          w_valid_clr = 1'b1;
          w_state_nxt = FETCH;
        end else if (if_en) begin
          w_from_skid = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      DROP: begin
        if (redirect) w_pc_nxt = w_redirect_pc;
        if (redirect || if_rst || if_en) w_valid_clr = 1'b1;
        if (w_ack) w_state_nxt = FETCH;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC_ALIGNED;
      r_addr  <= RESET_PC_ALIGNED;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      // The address of an abandoned request must stay put until its ack arrives.
      if (w_state_nxt != DROP) r_addr <= w_pc_nxt;
    end
  end

  // NOTE: the skid entry is reset too; its contents are observable only through FULL, but a defined value keeps X out of pc_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid  <= 1'b0;
      r_inst_out  <= 32'h0;
      r_pc_out    <= 32'h0;
      r_skid_inst <= 32'h0;
      r_skid_pc   <= 32'h0;
    end else begin
      if (w_load_skid) begin
        r_skid_inst <= w_data;
        r_skid_pc   <= r_pc;
      end
      if (w_load_out) begin
        r_inst_out <= w_data;
        r_pc_out   <= r_pc;
        r_if_valid <= 1'b1;
      end else if (w_from_skid) begin
        r_inst_out <= r_skid_inst;
        r_pc_out   <= r_skid_pc;
        r_if_valid <= 1'b1;
      end else if (w_valid_clr) begin
        r_if_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  logic       r_fetch_err;

  assign w_tmo = w_busy && !imem_ack && (r_tmo_cnt == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt   <= 8'h00;
      r_fetch_err <= 1'b0;
    end else begin
      if (redirect || imem_ack || w_tmo || !w_busy) r_tmo_cnt <= 8'h00;
      else                                          r_tmo_cnt <= r_tmo_cnt + 8'd1;
      if (w_tmo && (r_state == FETCH) && !redirect) r_fetch_err <= 1'b1;
    end
  end

  assign fetch_err = r_fetch_err;
`else
  assign w_tmo     = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign imem_req  = w_busy;
  assign imem_addr = r_addr;
  assign if_valid  = r_if_valid;
  assign inst_out  = r_inst_out;
  assign pc_out    = r_pc_out;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected {pc, inst}; a negedge monitor pops on each consumed output.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_rst = 1'b0, if_en = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid, imem_req, imem_ack, fetch_err;
  logic [31:0] imem_addr, imem_data, inst_out, pc_out;
  logic        zero_wait = 1'b0, man_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_data = mem_word(imem_addr);
  assign imem_ack  = zero_wait ? imem_req : man_ack;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .if_rst(if_rst), .if_en(if_en), .if_valid(if_valid),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .inst_out(inst_out), .pc_out(pc_out), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    e.pc = pc;
    e.inst = inst;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: an output is consumed at the next rising edge when if_valid and if_en are both high.
  always @(negedge clk) begin
    if (rst_n && if_valid && if_en) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h expected no output", pc_out, inst_out);
      end else begin
        e = sb.pop_front();
        if (pc_out !== e.pc || inst_out !== e.inst) begin
          errors++;
          $display("FAIL sb_output: got pc=%h inst=%h expected pc=%h inst=%h",
                   pc_out, inst_out, e.pc, e.inst);
        end
      end
    end
  end

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, if_valid}, 32'h0);
    check("rst_inst", inst_out, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_err", {31'b0, fetch_err}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("idle_to_fetch_req", {31'b0, imem_req}, 32'h1);
    check("idle_to_fetch_addr", imem_addr, 32'h0);

    // Zero-wait streaming: one instruction per cycle
    zero_wait = 1'b1;
    if_en = 1'b1;
    for (int i = 0; i < 4; i++) push(32'(4 * i), mem_word(32'(4 * i)));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stream_valid", {31'b0, if_valid}, 32'h1);
      check("stream_pc", pc_out, 32'(4 * i));
    end
    zero_wait = 1'b0;
    tick();
    check("bubble_valid", {31'b0, if_valid}, 32'h0);
    check("bubble_addr", imem_addr, 32'h10);

    // Redirect with same-cycle ack discards the response for 0x10
    redirect = 1'b1; redirect_pc = 32'h4; man_ack = 1'b1;
    tick();
    redirect = 1'b0;
    check("redir_ack_addr", imem_addr, 32'h4);
    check("redir_ack_valid", {31'b0, if_valid}, 32'h0);

    // Skid buffer: ack for 8 while output held
    push(32'h4, mem_word(32'h4));
    tick();
    check("skid_pre_pc", pc_out, 32'h4);
    check("skid_pre_addr", imem_addr, 32'h8);
    if_en = 1'b0;
    tick();
    man_ack = 1'b0;
    check("full_req", {31'b0, imem_req}, 32'h0);
    check("full_hold_pc", pc_out, 32'h4);
    check("full_hold_valid", {31'b0, if_valid}, 32'h1);
    tick();
    check("full_stay_req", {31'b0, imem_req}, 32'h0);
    check("full_stay_pc", pc_out, 32'h4);
    if_en = 1'b1;
    push(32'h8, mem_word(32'h8));
    tick();
    check("unskid_pc", pc_out, 32'h8);
    check("unskid_inst", inst_out, mem_word(32'h8));
    check("unskid_req", {31'b0, imem_req}, 32'h1);
    check("unskid_addr", imem_addr, 32'hC);
    tick();
    check("unskid_bubble", {31'b0, if_valid}, 32'h0);

    // Delayed ack with redirect to 0x100 while pending
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("drop_addr_hold", imem_addr, 32'hC);
    check("drop_req", {31'b0, imem_req}, 32'h1);
    tick();
    check("drop_addr_hold2", imem_addr, 32'hC);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    check("drop_done_addr", imem_addr, 32'h100);
    check("drop_done_valid", {31'b0, if_valid}, 32'h0);

    // Flush: pc unchanged, pending request dropped
    if_rst = 1'b1;
    tick();
    if_rst = 1'b0;
    check("flush_addr", imem_addr, 32'h100);
    man_ack = 1'b1;
    tick();
    check("flush_refetch_addr", imem_addr, 32'h100);
    check("flush_refetch_valid", {31'b0, if_valid}, 32'h0);
    push(32'h100, mem_word(32'h100));
    tick();
    check("post_flush_pc", pc_out, 32'h100);
    check("post_flush_addr", imem_addr, 32'h104);

    // PC wrap; redirect_pc low bits are ignored
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    check("wrap_redir_addr", imem_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
    tick();
    check("wrap_addr", imem_addr, 32'h0);
    push(32'h0, mem_word(32'h0));
    tick();
    man_ack = 1'b0;
    check("wrap_next_addr", imem_addr, 32'h4);

    // Async reset with a pending request; late ack in IDLE ignored
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_req", {31'b0, imem_req}, 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_valid", {31'b0, if_valid}, 32'h0);
    check("arst_pc_out", pc_out, 32'h0);
    check("arst_inst", inst_out, 32'h0);
    tick();
    man_ack = 1'b1;
    rst_n = 1'b1;
    tick();
    check("late_ack_valid", {31'b0, if_valid}, 32'h0);
    check("refetch_addr", imem_addr, 32'h0);
    check("refetch_req", {31'b0, imem_req}, 32'h1);
    push(32'h0, mem_word(32'h0));
    tick();
    man_ack = 1'b0;
    check("refetch_pc", pc_out, 32'h0);
    check("refetch_next_addr", imem_addr, 32'h4);

`ifdef FETCH_TIMEOUT_EN
    // 255 waiting cycles, then a NOP is injected for address 4
    repeat (255) tick();
    check("tmo_err_before", {31'b0, fetch_err}, 32'h0);
    check("tmo_valid_before", {31'b0, if_valid}, 32'h0);
    push(32'h4, 32'h0);
    tick();
    check("tmo_valid", {31'b0, if_valid}, 32'h1);
    check("tmo_inst", inst_out, 32'h0);
    check("tmo_pc", pc_out, 32'h4);
    check("tmo_err", {31'b0, fetch_err}, 32'h1);
    check("tmo_next_addr", imem_addr, 32'h8);
    tick();
    check("tmo_err_sticky", {31'b0, fetch_err}, 32'h1);
`else
    // Without the watchdog the wait is unbounded and fetch_err stays low
    repeat (300) tick();
    check("no_tmo_err", {31'b0, fetch_err}, 32'h0);
    check("no_tmo_valid", {31'b0, if_valid}, 32'h0);
    check("no_tmo_addr", imem_addr, 32'h4);
    check("no_tmo_req", {31'b0, imem_req}, 32'h1);
`endif

    if_en = 1'b0;
    tick();
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
